// File: rtl/hc_link_map_gen.sv
`default_nettype none
// ============================================================================
//  Module   : hc_link_map_gen
//  Purpose  : Streams one record per node of an incomplete hypercube with
//             N = 2^n + m nodes (IDs 0..N-1). Each record carries the node ID
//             and a per-dimension mask saying which neighbours exist.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk_i       : clock, rising edge
//    rst_n_i     : asynchronous active-low reset
//    start_i     : start request, sampled only in IDLE
//    n_i, m_i    : power index n and remainder m of the node count
//    flush_i     : synchronous abort back to IDLE, highest priority
//    ready_i     : consumer ready
//    valid_o     : record valid (high for the whole RUN state)
//    node_id_o   : current node ID
//    nbr_mask_o  : bit d set iff (id ^ 2^d) < N and d < D
//    last_o      : current record is node N-1
//    node_cnt_o  : latched N
//    dim_o       : latched D = n + (m != 0)
//    busy_o      : high in RUN
//    done_o      : one-cycle pulse after the final handshake
//    err_o       : one-cycle pulse on a rejected start (n_i > 4)
// ============================================================================
module hc_link_map_gen #(
  parameter int ID_W   = 5,
  parameter int MASK_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic [2:0]        n_i,
  input  logic [2:0]        m_i,
  input  logic              flush_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [ID_W-1:0]   node_id_o,
  output logic [MASK_W-1:0] nbr_mask_o,
  output logic              last_o,
  output logic [ID_W-1:0]   node_cnt_o,
  output logic [2:0]        dim_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [ID_W:0] c_one_wide = {{ID_W{1'b0}}, 1'b1};

  state_t              r_state;
  logic                r_valid;
  logic [ID_W-1:0]     r_id;
  logic [MASK_W-1:0]   r_mask;
  logic                r_last;
  logic [ID_W-1:0]     r_node_cnt;
  logic [2:0]          r_dim;
  logic                r_busy;
  logic                r_done;
  logic                r_err;

  // Neighbour mask for a given node. The flipped ID is formed one bit wider
  // than the ID so flipping the top bit can never wrap below N.
  function automatic logic [MASK_W-1:0] f_mask(
    input logic [ID_W-1:0] id,
    input logic [ID_W-1:0] cnt,
    input logic [2:0]      dim
  );
    logic [ID_W:0] flip;
    f_mask = '0;
    for (int d = 0; d < MASK_W; d++) begin
      flip = {1'b0, id} ^ (c_one_wide << d);
      if ((d < int'(dim)) && (flip < {1'b0, cnt})) begin
        f_mask[d] = 1'b1;
      end
    end
  endfunction

  // Values latched on an accepted start. n = 4 already fills the 16-node
  // cube, so m is ignored there.
  logic [ID_W-1:0]   w_pow;
  logic [ID_W-1:0]   w_start_sum;
  logic [ID_W-1:0]   w_start_cnt;
  logic [2:0]        w_start_dim;
  logic              w_start_last;
  logic [MASK_W-1:0] w_start_mask;

  assign w_pow        = ID_W'(1) << n_i;
  assign w_start_sum  = w_pow + ID_W'(m_i);
  assign w_start_cnt  = (n_i == 3'd4) ? w_pow : w_start_sum;
  assign w_start_dim  = (n_i == 3'd4) ? 3'd4 : (n_i + {2'b00, (m_i != 3'd0)});
  assign w_start_last = (w_start_cnt == ID_W'(1));
  assign w_start_mask = f_mask('0, w_start_cnt, w_start_dim);

  // Next record during RUN, computed ahead so the data outputs are plain
  // registers with no path from ready_i.
  logic [ID_W-1:0]   w_id_nxt;
  logic              w_last_nxt;
  logic [MASK_W-1:0] w_mask_nxt;

  assign w_id_nxt   = r_id + ID_W'(1);
  assign w_last_nxt = ((w_id_nxt + ID_W'(1)) == r_node_cnt);
  assign w_mask_nxt = f_mask(w_id_nxt, r_node_cnt, r_dim);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state    <= S_IDLE;
      r_valid    <= 1'b0;
      r_id       <= '0;
      r_mask     <= '0;
      r_last     <= 1'b0;
      r_node_cnt <= '0;
      r_dim      <= 3'd0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else if (flush_i) begin
      // Geometry (node count, dimension) is kept for the consumer.
      r_state <= S_IDLE;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          r_err  <= 1'b0;
          if (start_i) begin
            if (n_i <= 3'd4) begin
              r_state    <= S_RUN;
              r_valid    <= 1'b1;
              r_busy     <= 1'b1;
              r_id       <= '0;
              r_mask     <= w_start_mask;
              r_last     <= w_start_last;
              r_node_cnt <= w_start_cnt;
              r_dim      <= w_start_dim;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (ready_i) begin
            if (r_last) begin
              r_state <= S_DONE;
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_id   <= w_id_nxt;
              r_mask <= w_mask_nxt;
              r_last <= w_last_nxt;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_err   <= 1'b0;
        end
      endcase
    end
  end

  assign valid_o    = r_valid;
  assign node_id_o  = r_id;
  assign nbr_mask_o = r_mask;
  assign last_o     = r_last;
  assign node_cnt_o = r_node_cnt;
  assign dim_o      = r_dim;
  assign busy_o     = r_busy;
  assign done_o     = r_done;
  assign err_o      = r_err;

endmodule
`default_nettype wire
